// File: rtl/if_id_fetch_pkg.sv
// Shared constants and IF/ID select encoding for the miniRV fetch stage.
package if_id_fetch_pkg;

    // Bubble encoding: addi x0,x0,0
    localparam logic [31:0] NOP_INST        = 32'h0000_0013;
    // Opcode bit set for every control-transfer (jal/jalr/B-type)
    localparam int          OPCODE_CTRL_BIT = 6;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    // Marks a bubble in ID; never a fetchable (word-aligned) address
    localparam logic [31:0] BUBBLE_PC_DEF   = 32'hFFFF_FFFF;

    // What the IF/ID register does this cycle; exactly one counter follows it
    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_HOLD   = 2'd2
    } ifid_sel_e;

    // Stall beats duplicate-squash, which beats a normal load
    function automatic ifid_sel_e ifid_select(input logic stall, input logic duplicate);
        if (stall)
            return IFID_HOLD;
        else if (duplicate)
            return IFID_BUBBLE;
        else
            return IFID_LOAD;
    endfunction

endpackage

// File: rtl/if_id_fetch_if.sv
// Fetch-stage signal bundle: hazard unit / ROM side is master, fetch block is slave.
interface if_id_fetch_if #(
    parameter int IROM_AW = 14
);
    logic [31:0]        IF_npc;
    logic               dpc_control;
    logic [IROM_AW-1:0] irom_addr;
    logic [31:0]        irom_inst;
    logic [31:0]        IF_pc;
    logic [31:0]        IF_inst;
    logic [31:0]        ID_pc;
    logic [31:0]        ID_inst;
    logic               ID_valid;
    logic [31:0]        fetch_cnt;
    logic [31:0]        bubble_cnt;
    logic [31:0]        stall_cnt;

    modport master (
        output IF_npc, dpc_control, irom_inst,
        input  irom_addr, IF_pc, IF_inst, ID_pc, ID_inst, ID_valid,
               fetch_cnt, bubble_cnt, stall_cnt
    );

    modport slave (
        input  IF_npc, dpc_control, irom_inst,
        output irom_addr, IF_pc, IF_inst, ID_pc, ID_inst, ID_valid,
               fetch_cnt, bubble_cnt, stall_cnt
    );
endinterface

// File: rtl/if_id_fetch_if_id_reg.sv
// IF/ID pipeline register with hold / bubble / load selection.
module if_id_fetch_if_id_reg
    import if_id_fetch_pkg::*;
#(
    parameter logic [31:0] BUBBLE_PC = BUBBLE_PC_DEF,
    parameter logic [31:0] NOP_VAL   = NOP_INST
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        dpc_control,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output ifid_sel_e   sel
);

    logic [31:0] id_pc_reg;
    logic [31:0] id_inst_reg;
    logic        id_valid_reg;

    // A held control transfer shows up as IF re-presenting the PC already in ID
    always_comb begin
        sel = ifid_select(dpc_control, id_valid_reg && (id_pc_reg == if_pc));
    end

    // IF/ID state update
    always_ff @(posedge clk) begin
        if (srst) begin
            id_pc_reg    <= BUBBLE_PC;
            id_inst_reg  <= NOP_VAL;
            id_valid_reg <= 1'b0;
        end else begin
            case (sel)
                IFID_HOLD: begin
                    id_pc_reg    <= id_pc_reg;
                    id_inst_reg  <= id_inst_reg;
                    id_valid_reg <= id_valid_reg;
                end
                IFID_BUBBLE: begin
                    id_pc_reg    <= BUBBLE_PC;
                    id_inst_reg  <= NOP_VAL;
                    id_valid_reg <= 1'b0;
                end
                default: begin
                    id_pc_reg    <= if_pc;
                    id_inst_reg  <= if_inst;
                    id_valid_reg <= 1'b1;
                end
            endcase
        end
    end

    assign id_pc    = id_pc_reg;
    assign id_inst  = id_inst_reg;
    assign id_valid = id_valid_reg;

endmodule

// File: rtl/if_id_fetch.sv
// miniRV fetch stage: PC register, instruction-ROM addressing, IF/ID register, perf counters.
module if_id_fetch
    import if_id_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] BUBBLE_PC = BUBBLE_PC_DEF,
    parameter int          IROM_AW   = 14,
    parameter logic [31:0] NOP_VAL   = NOP_INST
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    if_id_fetch_if.slave  bus
);

    logic [31:0] pc_reg;
    logic [31:0] fetch_cnt_reg;
    logic [31:0] bubble_cnt_reg;
    logic [31:0] stall_cnt_reg;
    ifid_sel_e   ifid_sel;

    // PC follows IF_npc unconditionally; holds are the hazard unit's job
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst)
            pc_reg <= RESET_PC;
        else
            pc_reg <= bus.IF_npc;
    end

    // ROM is word addressed; PC[1:0] are dropped without any alignment check
    assign bus.irom_addr = pc_reg[IROM_AW+1:2];
    assign bus.IF_pc     = pc_reg;
    assign bus.IF_inst   = bus.irom_inst;

    if_id_fetch_if_id_reg #(
        .BUBBLE_PC (BUBBLE_PC),
        .NOP_VAL   (NOP_VAL)
    ) u_if_id_reg (
        .clk         (cpu_clk),
        .srst        (cpu_rst),
        .dpc_control (bus.dpc_control),
        .if_pc       (pc_reg),
        .if_inst     (bus.irom_inst),
        .id_pc       (bus.ID_pc),
        .id_inst     (bus.ID_inst),
        .id_valid    (bus.ID_valid),
        .sel         (ifid_sel)
    );

    // Exactly one counter advances per cycle, mirroring the IF/ID action
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            fetch_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            case (ifid_sel)
                IFID_HOLD:   stall_cnt_reg  <= stall_cnt_reg + 32'd1;
                IFID_BUBBLE: bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
                default:     fetch_cnt_reg  <= fetch_cnt_reg + 32'd1;
            endcase
        end
    end

    assign bus.fetch_cnt  = fetch_cnt_reg;
    assign bus.bubble_cnt = bubble_cnt_reg;
    assign bus.stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed bench for if_id_fetch with a small ROM and branch-hazard-unit model.
module tb_if_id_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BPC  = 32'hFFFF_FFFF;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [6:0]  BR_OP = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_force = 1'b0;
    logic [31:0] br_target = 32'h20;
    logic [31:0] rom [0:63];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    if_id_fetch_if #(.IROM_AW(14)) bus ();

    if_id_fetch dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.irom_inst   = rom[bus.irom_addr[5:0]];
    assign bus.dpc_control = stall_force;

    // Branch hazard unit model: hold PC on a fetched branch, redirect once it sits duplicated in ID
    always_comb begin
        bus.IF_npc = bus.IF_pc + 32'd4;
        if (stall_force)
            bus.IF_npc = bus.IF_pc;
        else if (bus.ID_valid && bus.ID_pc == bus.IF_pc && bus.ID_inst[6:0] == BR_OP)
            bus.IF_npc = br_target;
        else if (bus.IF_inst[6:0] == BR_OP)
            bus.IF_npc = bus.IF_pc;
    end

    function automatic logic [31:0] addi_word(input int i);
        return 32'h0000_0093 | (32'(i) << 20);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc=%0d rst=%0b stall=%0b IF_pc=%h ID_pc=%h ID_inst=%h ID_valid=%0b f=%0d b=%0d s=%0d",
                 cyc, rst, stall_force, bus.IF_pc, bus.ID_pc, bus.ID_inst, bus.ID_valid,
                 bus.fetch_cnt, bus.bubble_cnt, bus.stall_cnt);
    endtask

    task automatic load_rom(input logic branch_at_8);
        for (int i = 0; i < 64; i++) rom[i] = addi_word(i);
        if (branch_at_8) rom[2] = BEQ;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        load_rom(1'b0);
        apply_reset();
        checks++; if (bus.IF_pc !== 32'h0) begin failures++; $display("FAIL reset_if_pc got=%h exp=%h", bus.IF_pc, 32'h0); end
        checks++; if (bus.ID_pc !== BPC) begin failures++; $display("FAIL reset_id_pc got=%h exp=%h", bus.ID_pc, BPC); end
        checks++; if (bus.ID_inst !== NOP) begin failures++; $display("FAIL reset_id_inst got=%h exp=%h", bus.ID_inst, NOP); end
        checks++; if (bus.ID_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", bus.ID_valid); end
        checks++; if ({bus.fetch_cnt, bus.bubble_cnt, bus.stall_cnt} !== 96'h0) begin failures++;
            $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", bus.fetch_cnt, bus.bubble_cnt, bus.stall_cnt); end
        checks++; if (bus.irom_addr !== 14'h0) begin failures++; $display("FAIL reset_irom_addr got=%h exp=0", bus.irom_addr); end
    endtask

    task automatic test_straight_line();
        load_rom(1'b0);
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (bus.IF_pc !== 32'(4*k)) begin failures++; $display("FAIL line_if_pc k=%0d got=%h exp=%h", k, bus.IF_pc, 32'(4*k)); end
            checks++; if (bus.ID_pc !== 32'(4*(k-1))) begin failures++; $display("FAIL line_id_pc k=%0d got=%h exp=%h", k, bus.ID_pc, 32'(4*(k-1))); end
            checks++; if (bus.ID_inst !== addi_word(k-1)) begin failures++; $display("FAIL line_id_inst k=%0d got=%h exp=%h", k, bus.ID_inst, addi_word(k-1)); end
            checks++; if (bus.ID_valid !== 1'b1) begin failures++; $display("FAIL line_id_valid k=%0d got=%b exp=1", k, bus.ID_valid); end
        end
        checks++; if (bus.fetch_cnt !== 32'd4) begin failures++; $display("FAIL line_fetch_cnt got=%0d exp=4", bus.fetch_cnt); end
        checks++; if (bus.irom_addr !== 14'd4) begin failures++; $display("FAIL line_irom_addr got=%h exp=4", bus.irom_addr); end
    endtask

    task automatic test_branch();
        load_rom(1'b1);
        br_target = 32'h20;
        apply_reset();
        step(); step(); step();
        // ID holds beq@8 while IF re-presents 8
        checks++; if (bus.ID_pc !== 32'h8 || bus.ID_inst !== BEQ || bus.ID_valid !== 1'b1) begin failures++;
            $display("FAIL br_id_beq got=%h/%h/%b exp=00000008/%h/1", bus.ID_pc, bus.ID_inst, bus.ID_valid, BEQ); end
        checks++; if (bus.IF_pc !== 32'h8) begin failures++; $display("FAIL br_if_hold got=%h exp=00000008", bus.IF_pc); end
        step();
        checks++; if (bus.ID_valid !== 1'b0 || bus.ID_pc !== BPC || bus.ID_inst !== NOP) begin failures++;
            $display("FAIL br_bubble got=%h/%h/%b exp=%h/%h/0", bus.ID_pc, bus.ID_inst, bus.ID_valid, BPC, NOP); end
        checks++; if (bus.IF_pc !== 32'h20) begin failures++; $display("FAIL br_target got=%h exp=00000020", bus.IF_pc); end
        checks++; if (bus.bubble_cnt !== 32'd1) begin failures++; $display("FAIL br_bubble_cnt got=%0d exp=1", bus.bubble_cnt); end
        step();
        checks++; if (bus.ID_pc !== 32'h20 || bus.ID_valid !== 1'b1) begin failures++;
            $display("FAIL br_after got=%h/%b exp=00000020/1", bus.ID_pc, bus.ID_valid); end
        checks++; if (bus.fetch_cnt !== 32'd4) begin failures++; $display("FAIL br_fetch_cnt got=%0d exp=4", bus.fetch_cnt); end
    endtask

    // Continues from test_branch: IF_pc=0x24, ID=0x20
    task automatic test_data_stall();
        stall_force = 1'b1;
        step(); step();
        stall_force = 1'b0;
        checks++; if (bus.ID_pc !== 32'h20 || bus.ID_inst !== addi_word(8) || bus.ID_valid !== 1'b1) begin failures++;
            $display("FAIL stall_frozen got=%h/%h/%b exp=00000020/%h/1", bus.ID_pc, bus.ID_inst, bus.ID_valid, addi_word(8)); end
        checks++; if (bus.stall_cnt !== 32'd2) begin failures++; $display("FAIL stall_cnt got=%0d exp=2", bus.stall_cnt); end
        checks++; if (bus.fetch_cnt !== 32'd4) begin failures++; $display("FAIL stall_fetch_cnt got=%0d exp=4", bus.fetch_cnt); end
        step();
        checks++; if (bus.ID_pc !== 32'h24 || bus.IF_pc !== 32'h28 || bus.fetch_cnt !== 32'd5) begin failures++;
            $display("FAIL stall_release got=%h/%h/%0d exp=00000024/00000028/5", bus.ID_pc, bus.IF_pc, bus.fetch_cnt); end
        checks++; if (bus.fetch_cnt + bus.bubble_cnt + bus.stall_cnt !== 32'd8) begin failures++;
            $display("FAIL counter_sum got=%0d exp=8", bus.fetch_cnt + bus.bubble_cnt + bus.stall_cnt); end
    endtask

    task automatic test_branch_to_self();
        load_rom(1'b1);
        br_target = 32'h8;
        apply_reset();
        step(); step(); step();
        for (int r = 1; r <= 2; r++) begin
            step();
            checks++; if (bus.ID_valid !== 1'b0 || bus.bubble_cnt !== 32'(r) || bus.IF_pc !== 32'h8) begin failures++;
                $display("FAIL self_bubble r=%0d got=%b/%0d/%h exp=0/%0d/00000008", r, bus.ID_valid, bus.bubble_cnt, bus.IF_pc, r); end
            step();
            checks++; if (bus.ID_valid !== 1'b1 || bus.ID_pc !== 32'h8 || bus.ID_inst !== BEQ) begin failures++;
                $display("FAIL self_refetch r=%0d got=%b/%h/%h exp=1/00000008/%h", r, bus.ID_valid, bus.ID_pc, bus.ID_inst, BEQ); end
        end
        // Stall outranks the duplicate squash
        stall_force = 1'b1;
        step();
        checks++; if (bus.ID_valid !== 1'b1 || bus.bubble_cnt !== 32'd2 || bus.stall_cnt !== 32'd1) begin failures++;
            $display("FAIL self_stall_prio got=%b/%0d/%0d exp=1/2/1", bus.ID_valid, bus.bubble_cnt, bus.stall_cnt); end
        stall_force = 1'b0;
        step();
        checks++; if (bus.ID_valid !== 1'b0 || bus.bubble_cnt !== 32'd3) begin failures++;
            $display("FAIL self_after_stall got=%b/%0d exp=0/3", bus.ID_valid, bus.bubble_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        load_rom(1'b0);
        apply_reset();
        step(); step();
        stall_force = 1'b1;
        step();
        rst = 1'b1;
        step();
        checks++; if (bus.IF_pc !== 32'h0 || bus.ID_pc !== BPC || bus.ID_inst !== NOP || bus.ID_valid !== 1'b0) begin failures++;
            $display("FAIL rst_stall_state got=%h/%h/%h/%b exp=00000000/%h/%h/0", bus.IF_pc, bus.ID_pc, bus.ID_inst, bus.ID_valid, BPC, NOP); end
        checks++; if ({bus.fetch_cnt, bus.bubble_cnt, bus.stall_cnt} !== 96'h0) begin failures++;
            $display("FAIL rst_stall_counters got=%0d/%0d/%0d exp=0/0/0", bus.fetch_cnt, bus.bubble_cnt, bus.stall_cnt); end
        stall_force = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_branch();
        test_data_stall();
        test_branch_to_self();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
